// File: rtl/mul_arb_pkg.sv
// Shared constants, pipeline stage type and round-robin pick helper for the
// shared multiplier arbiter.
package mul_arb_pkg;

  localparam int DEF_INWD = 8;
  localparam int DEF_NREQ = 4;
  localparam int DEF_IDW  = $clog2(DEF_NREQ);
  localparam int MAX_NREQ = 32;

  typedef struct packed {
    logic                    valid;
    logic [DEF_IDW-1:0]      id;
    logic [2*DEF_INWD-1:0]   product;
  } stage_t;

  // First set bit of req[0 +: n], scanning cyclically upward from ptr; -1 if none.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] req,
                                 input int ptr, input int n);
    int pick;
    int idx;
    pick = -1;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// MUL_LAT-deep product pipeline with a global advance enable; the multiply
// happens as the operands enter stage 0.
module mul_pipe
  import mul_arb_pkg::*;
#(
  parameter int  INWD    = DEF_INWD,
  parameter int  IDW     = DEF_IDW,
  parameter int  MUL_LAT = 1,
  parameter type st_t    = stage_t
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [IDW-1:0]    in_id,
  input  logic [INWD-1:0]   in_a,
  input  logic [INWD-1:0]   in_b,
  output logic              out_valid,
  output logic [IDW-1:0]    out_id,
  output logic [2*INWD-1:0] out_c,
  output logic              busy
);

  st_t stg [MUL_LAT];

  // Payload only moves with a valid entry, so the last stage keeps showing
  // the most recent result while bubbles pass through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) stg[i] <= '0;
    end else if (en) begin
      stg[0].valid <= in_valid;
      if (in_valid) begin
        stg[0].id      <= in_id;
        stg[0].product <= (2*INWD)'(in_a) * (2*INWD)'(in_b);
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        stg[i].valid <= stg[i-1].valid;
        if (stg[i-1].valid) begin
          stg[i].id      <= stg[i-1].id;
          stg[i].product <= stg[i-1].product;
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | stg[i].valid;
    out_valid = stg[MUL_LAT-1].valid;
    out_id    = stg[MUL_LAT-1].id;
    out_c     = stg[MUL_LAT-1].product;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier among NREQ
// requesters; results leave tagged with the issuing requester index.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int INWD    = DEF_INWD,
  parameter  int NREQ    = DEF_NREQ,
  parameter  int MUL_LAT = 1,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      iReqValid,
  output logic [NREQ-1:0]      oReqReady,
  input  logic [NREQ*INWD-1:0] iA,
  input  logic [NREQ*INWD-1:0] iB,
  output logic                 oValid,
  output logic [IDW-1:0]       oId,
  output logic [2*INWD-1:0]    oC,
  input  logic                 iReady,
  output logic                 oBusy
);

  typedef struct packed {
    logic               valid;
    logic [IDW-1:0]     id;
    logic [2*INWD-1:0]  product;
  } pipe_stage_t;

  logic            en;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  ptr;
  logic [INWD-1:0] a_sel;
  logic [INWD-1:0] b_sel;
  int              pick;

  // Handshakes: a request moves when iReqValid[i] & oReqReady[i]; a result
  // moves when oValid & iReady. A stalled output (oValid & ~iReady) freezes
  // the pipeline and suppresses every grant, so oReqReady sees iReady only via en.
  assign en = ~(oValid & ~iReady);

  always_comb begin
    pick      = rr_pick(MAX_NREQ'(iReqValid), int'(ptr), NREQ);
    grant_any = en & ~rst & (pick >= 0);
    grant_id  = grant_any ? IDW'(pick) : '0;
    oReqReady = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && grant_id == IDW'(i)) begin
        oReqReady[i] = 1'b1;
        a_sel        = iA[i*INWD +: INWD];
        b_sel        = iB[i*INWD +: INWD];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  mul_pipe #(
    .INWD    (INWD),
    .IDW     (IDW),
    .MUL_LAT (MUL_LAT),
    .st_t    (pipe_stage_t)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (grant_any),
    .in_id     (grant_id),
    .in_a      (a_sel),
    .in_b      (b_sel),
    .out_valid (oValid),
    .out_id    (oId),
    .out_c     (oC),
    .busy      (oBusy)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: one instance with MUL_LAT=1 and one with
// MUL_LAT=3 exercised by a scoreboarded random-traffic phase and reset checks.
module tb_mul_arbiter;

  localparam int NREQ = 4;
  localparam int INWD = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic rst3 = 1'b1;

  // MUL_LAT = 1 instance
  logic [NREQ-1:0]      req_v = '0;
  logic [NREQ-1:0]      req_r;
  logic [NREQ*INWD-1:0] a = '0;
  logic [NREQ*INWD-1:0] b = '0;
  logic                 rdy = 1'b1;
  logic                 o_valid;
  logic [1:0]           o_id;
  logic [2*INWD-1:0]    o_c;
  logic                 busy;

  // MUL_LAT = 3 instance
  logic [NREQ-1:0]      req_v3 = '0;
  logic [NREQ-1:0]      req_r3;
  logic [NREQ*INWD-1:0] a3 = '0;
  logic [NREQ*INWD-1:0] b3 = '0;
  logic                 rdy3 = 1'b1;
  logic                 o_valid3;
  logic [1:0]           o_id3;
  logic [2*INWD-1:0]    o_c3;
  logic                 busy3;

  mul_arbiter #(.INWD(INWD), .NREQ(NREQ), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .iReqValid(req_v), .oReqReady(req_r),
    .iA(a), .iB(b), .oValid(o_valid), .oId(o_id), .oC(o_c),
    .iReady(rdy), .oBusy(busy)
  );

  mul_arbiter #(.INWD(INWD), .NREQ(NREQ), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .iReqValid(req_v3), .oReqReady(req_r3),
    .iA(a3), .iB(b3), .oValid(o_valid3), .oId(o_id3), .oC(o_c3),
    .iReady(rdy3), .oBusy(busy3)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          mptr;
  int          exp_g;
  int          idx;
  int          wait_cnt [NREQ];
  logic [3:0]  exp_rr;
  logic        stall;
  logic [7:0]  ga;
  logic [7:0]  gb;
  logic [17:0] e;
  int          last_g;

  initial begin
    // ---------------- reset state ----------------
    req_v  = 4'hF;
    req_v3 = 4'hF;
    #2;
    check("rst_ready",  32'(req_r), 0);
    check("rst_valid",  32'(o_valid), 0);
    check("rst_id",     32'(o_id), 0);
    check("rst_c",      32'(o_c), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst3_ready", 32'(req_r3), 0);
    check("rst3_busy",  32'(busy3), 0);
    req_v  = '0;
    req_v3 = '0;
    step();
    rst  = 1'b0;
    rst3 = 1'b0;

    // ---------------- single requester 2: 200*3 ----------------
    req_v = 4'b0100;
    a[23:16] = 8'd200;
    b[23:16] = 8'd3;
    #1;
    check("single_grant", 32'(req_r), 32'h4);
    step();
    req_v = '0;
    #1;
    check("single_valid", 32'(o_valid), 1);
    check("single_id",    32'(o_id), 2);
    check("single_c",     32'(o_c), 600);
    check("single_busy",  32'(busy), 1);
    step();
    check("single_drain_valid", 32'(o_valid), 0);
    check("single_hold_c",      32'(o_c), 600);
    check("single_drain_busy",  32'(busy), 0);

    // ---------------- all four valid: rotation from ptr=3 ----------------
    // products: id0 10*3=30, id1 20*4=80, id2 30*5=150, id3 40*6=240
    a = {8'd40, 8'd30, 8'd20, 8'd10};
    b = {8'd6,  8'd5,  8'd4,  8'd3};
    req_v = 4'hF;
    last_g = 0;
    for (int k = 0; k < 6; k++) begin
      exp_g = (3 + k) % 4;
      #1;
      check("rot_grant", 32'(req_r), 32'(4'b1 << exp_g));
      if (k > 0) begin
        check("rot_valid", 32'(o_valid), 1);
        check("rot_id",    32'(o_id), 32'(last_g));
        check("rot_c",     32'(o_c), 32'((last_g + 1) * 10 * (last_g + 3)));
      end
      last_g = exp_g;
      step();
    end

    // ---------------- backpressure: id0 result (30) pending ----------------
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 32'(o_valid), 1);
      check("bp_id",    32'(o_id), 0);
      check("bp_c",     32'(o_c), 30);
      check("bp_ready", 32'(req_r), 0);
      step();
    end
    rdy = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_r), 32'h2);
    check("bp_release_valid", 32'(o_valid), 1);
    step();
    req_v = '0;
    #1;
    check("bp_next_id", 32'(o_id), 1);
    check("bp_next_c",  32'(o_c), 80);
    step();

    // ---------------- extremes on requester 0 ----------------
    req_v = 4'b0001;
    a[7:0] = 8'd255;
    b[7:0] = 8'd255;
    #1;
    check("ext_grant", 32'(req_r), 32'h1);
    step();
    a[7:0] = 8'd0;
    #1;
    check("ext_max_c",   32'(o_c), 65025);
    check("ext_max_id",  32'(o_id), 0);
    check("ext_grant2",  32'(req_r), 32'h1);
    step();
    req_v = '0;
    #1;
    check("ext_zero_valid", 32'(o_valid), 1);
    check("ext_zero_c",     32'(o_c), 0);
    step();
    check("ext_idle_valid", 32'(o_valid), 0);

    // ---------------- MUL_LAT=3 random traffic ----------------
    mptr = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v3[i] && $urandom_range(0, 1) == 1) begin
          req_v3[i] = 1'b1;
          a3[i*8 +: 8] = 8'($urandom_range(0, 255));
          b3[i*8 +: 8] = 8'($urandom_range(0, 255));
          wait_cnt[i] = 0;
        end
      end
      rdy3 = ($urandom_range(0, 3) != 0);
      #1;
      stall = o_valid3 & ~rdy3;
      exp_g = -1;
      if (!stall) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (mptr + k) % NREQ;
          if (req_v3[idx] && exp_g < 0) exp_g = idx;
        end
      end
      exp_rr = (exp_g < 0) ? 4'b0 : 4'(4'b1 << exp_g);
      check("rand_grant", 32'(req_r3), 32'(exp_rr));
      if (o_valid3 && rdy3) begin
        check("rand_q_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rand_result", 32'({o_id3, o_c3}), 32'(e));
        end
      end
      if (exp_g >= 0) begin
        check("rand_wait", 32'(wait_cnt[exp_g] < NREQ), 1);
        ga = a3[exp_g*8 +: 8];
        gb = b3[exp_g*8 +: 8];
        exp_q.push_back({2'(exp_g), 16'(16'(ga) * 16'(gb))});
        for (int i = 0; i < NREQ; i++)
          if (i != exp_g && req_v3[i]) wait_cnt[i]++;
        mptr = (exp_g + 1) % NREQ;
      end
      step();
      if (exp_g >= 0) req_v3[exp_g] = 1'b0;
    end

    // drain: every issued product must come out exactly once
    req_v3 = '0;
    rdy3   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (o_valid3) begin
        check("drain_q_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("drain_result", 32'({o_id3, o_c3}), 32'(e));
        end
      end
      step();
    end
    check("drain_empty", 32'(exp_q.size()), 0);
    check("drain_busy",  32'(busy3), 0);

    // ---------------- async reset with two results in flight ----------------
    a3 = {4{8'd7}};
    b3 = {4{8'd9}};
    req_v3 = 4'b0011;
    step();
    step();
    req_v3 = '0;
    #1;
    check("inflight_busy",  32'(busy3), 1);
    check("inflight_valid", 32'(o_valid3), 0);
    rst3 = 1'b1;
    #1;
    check("arst_valid", 32'(o_valid3), 0);
    check("arst_busy",  32'(busy3), 0);
    check("arst_c",     32'(o_c3), 0);
    check("arst_id",    32'(o_id3), 0);
    req_v3 = 4'b1010;
    #1;
    check("arst_ready", 32'(req_r3), 0);
    rst3 = 1'b0;
    #1;
    check("post_rst_grant1", 32'(req_r3), 32'h2);
    step();
    req_v3 = 4'b1000;
    #1;
    check("post_rst_grant3", 32'(req_r3), 32'h8);
    step();
    req_v3 = '0;
    step();
    check("post_rst_valid1", 32'(o_valid3), 1);
    check("post_rst_id1",    32'(o_id3), 1);
    check("post_rst_c1",     32'(o_c3), 63);
    step();
    check("post_rst_id3",    32'(o_id3), 3);
    check("post_rst_valid3", 32'(o_valid3), 1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
